// File: rtl/cache_mem_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module   : cache_arb_pkg
// Purpose  : Shared state encoding and address-slice constants for the
//            cache/memory arbiter.
// Revision : 1.0 - initial release
// ============================================================================
package cache_arb_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'b00,
    REFILL    = 2'b01,
    WRITEBACK = 2'b10
  } arb_state_t;

  // Byte address layout: [ADR_WIDTH-1:4] line, [3:2] word, [1:0] byte
  localparam int c_ofs_lsb  = 2;
  localparam int c_ofs_msb  = 3;
  localparam int c_line_lsb = 4;

endpackage
`default_nettype wire

// File: rtl/cache_mem_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module   : cache_mem_arbiter_if
// Purpose  : Refill, writeback and memory word-port signals of the arbiter.
//            slave = arbiter view, master = requester/memory view.
// Revision : 1.0 - initial release
// ============================================================================
interface cache_mem_arbiter_if #(
  parameter int WORD_WIDTH        = 32,
  parameter int ADR_WIDTH         = 32,
  parameter int WORD_OFFSET_WIDTH = 2
);
  logic                         req_rf;
  logic [ADR_WIDTH-1:0]         adr_rf;
  logic                         ack_rf;
  logic [WORD_WIDTH-1:0]        dat_rf;
  logic [WORD_OFFSET_WIDTH-1:0] word_rf;
  logic                         last_rf;

  logic                         req_wb;
  logic [ADR_WIDTH-1:0]         adr_wb;
  logic [WORD_WIDTH-1:0]        dat_wb;
  logic [WORD_OFFSET_WIDTH-1:0] word_wb;
  logic                         ack_wb;
  logic                         last_wb;

  logic                         req_mem;
  logic                         rdwr_mem;
  logic [ADR_WIDTH-1:0]         adr_mem;
  logic [WORD_WIDTH-1:0]        dat_cc2mem;
  logic                         ack_mem;
  logic [WORD_WIDTH-1:0]        dat_mem2cc;

  modport slave (
    input  req_rf, adr_rf, req_wb, adr_wb, dat_wb, ack_mem, dat_mem2cc,
    output ack_rf, dat_rf, word_rf, last_rf, word_wb, ack_wb, last_wb,
           req_mem, rdwr_mem, adr_mem, dat_cc2mem
  );

  modport master (
    output req_rf, adr_rf, req_wb, adr_wb, dat_wb, ack_mem, dat_mem2cc,
    input  ack_rf, dat_rf, word_rf, last_rf, word_wb, ack_wb, last_wb,
           req_mem, rdwr_mem, adr_mem, dat_cc2mem
  );
endinterface
`default_nettype wire

// File: rtl/cache_mem_arbiter_mem_burst_seq.sv
`default_nettype none
// ============================================================================
// Module   : mem_burst_seq
// Purpose  : Loadable wrapping word counter plus beat counter for one
//            line burst; flags the final beat.
// Revision : 1.0 - initial release
// ============================================================================
module mem_burst_seq #(
  parameter int WORD_NUM          = 4,
  parameter int WORD_OFFSET_WIDTH = 2
) (
  input  wire logic                         clk,
  input  wire logic                         rst,
  input  wire logic                         i_load,
  input  wire logic [WORD_OFFSET_WIDTH-1:0] i_start_word,
  input  wire logic                         i_advance,
  output logic      [WORD_OFFSET_WIDTH-1:0] o_word,
  output logic                              o_last_beat
);

  localparam logic [WORD_OFFSET_WIDTH-1:0] c_last = WORD_OFFSET_WIDTH'(WORD_NUM - 1);

  logic [WORD_OFFSET_WIDTH-1:0] r_word;
  logic [WORD_OFFSET_WIDTH-1:0] r_beat;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_word <= '0;
      r_beat <= '0;
    end else if (i_load) begin
      r_word <= i_start_word;
      r_beat <= '0;
    end else if (i_advance) begin
      r_word <= (r_word == c_last) ? '0 : r_word + 1'b1;
      r_beat <= (r_beat == c_last) ? '0 : r_beat + 1'b1;
    end
  end

  assign o_word      = r_word;
  assign o_last_beat = (r_beat == c_last);

endmodule
`default_nettype wire

// File: rtl/cache_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : cache_mem_arbiter
// Purpose  : Shares the memory word port between critical-word-first line
//            refills and starvation-protected dirty-line writebacks.
//            Optional: ARB_HAZARD_CHECK_EN (same-line writeback goes first).
// Revision : 1.0 - initial release
// ============================================================================
module cache_mem_arbiter
  import cache_arb_pkg::*;
#(
  parameter int WORD_WIDTH        = 32,
  parameter int ADR_WIDTH         = 32,
  parameter int WORD_NUM          = 4,
  parameter int WORD_OFFSET_WIDTH = 2,
  parameter int STARVE_LIMIT      = 4
) (
  input wire logic           clk,
  input wire logic           rst,
  cache_mem_arbiter_if.slave bus
);

  localparam int c_starve_w = $clog2(STARVE_LIMIT + 1);
  localparam logic [c_starve_w-1:0] c_starve_max = c_starve_w'(STARVE_LIMIT);

  arb_state_t                    r_state;
  logic                          r_req_mem;
  logic                          r_rdwr_mem;
  logic [ADR_WIDTH-1:c_line_lsb] r_line;
  logic [c_starve_w-1:0]         r_starve_cnt;

  logic                          w_hazard;
  logic                          w_wb_first;
  logic                          w_grant_rf;
  logic                          w_grant_wb;
  logic                          w_load;
  logic                          w_advance;
  logic                          w_in_rf;
  logic                          w_in_wb;
  logic                          w_last_beat;
  logic [WORD_OFFSET_WIDTH-1:0]  w_start_word;
  logic [WORD_OFFSET_WIDTH-1:0]  w_word;

`ifdef ARB_HAZARD_CHECK_EN
  // A refill of a line still waiting to be written back would read stale data
  assign w_hazard = bus.req_rf && bus.req_wb &&
                    (bus.adr_rf[ADR_WIDTH-1:c_line_lsb] == bus.adr_wb[ADR_WIDTH-1:c_line_lsb]);
`else
  assign w_hazard = 1'b0;
`endif

  assign w_wb_first   = bus.req_wb && ((r_starve_cnt == c_starve_max) || w_hazard);
  assign w_grant_rf   = (r_state == IDLE) && bus.req_rf && !w_wb_first;
  assign w_grant_wb   = (r_state == IDLE) && bus.req_wb && !w_grant_rf;
  assign w_load       = w_grant_rf || w_grant_wb;
  assign w_start_word = w_grant_rf ? bus.adr_rf[c_ofs_msb:c_ofs_lsb] : '0;
  assign w_in_rf      = (r_state == REFILL);
  assign w_in_wb      = (r_state == WRITEBACK);
  assign w_advance    = (w_in_rf || w_in_wb) && bus.ack_mem;

  mem_burst_seq #(
    .WORD_NUM          (WORD_NUM),
    .WORD_OFFSET_WIDTH (WORD_OFFSET_WIDTH)
  ) u_seq (
    .clk          (clk),
    .rst          (rst),
    .i_load       (w_load),
    .i_start_word (w_start_word),
    .i_advance    (w_advance),
    .o_word       (w_word),
    .o_last_beat  (w_last_beat)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= IDLE;
      r_req_mem    <= 1'b0;
      r_rdwr_mem   <= 1'b0;
      r_line       <= '0;
      r_starve_cnt <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_grant_rf) begin
            r_state    <= REFILL;
            r_req_mem  <= 1'b1;
            r_rdwr_mem <= 1'b0;
            r_line     <= bus.adr_rf[ADR_WIDTH-1:c_line_lsb];
            if (bus.req_wb && (r_starve_cnt != c_starve_max))
              r_starve_cnt <= r_starve_cnt + 1'b1;
          end else if (w_grant_wb) begin
            r_state      <= WRITEBACK;
            r_req_mem    <= 1'b1;
            r_rdwr_mem   <= 1'b1;
            r_line       <= bus.adr_wb[ADR_WIDTH-1:c_line_lsb];
            r_starve_cnt <= '0;
          end
        end
        REFILL, WRITEBACK: begin
          // Burst runs to completion even if the requester drops its request
          if (bus.ack_mem && w_last_beat) begin
            r_state    <= IDLE;
            r_req_mem  <= 1'b0;
            r_rdwr_mem <= 1'b0;
          end
        end
        default: begin
          r_state    <= IDLE;
          r_req_mem  <= 1'b0;
          r_rdwr_mem <= 1'b0;
        end
      endcase
    end
  end

  assign bus.req_mem    = r_req_mem;
  assign bus.rdwr_mem   = r_rdwr_mem;
  assign bus.adr_mem    = {r_line, w_word, 2'b00};
  assign bus.dat_cc2mem = w_in_wb ? bus.dat_wb : '0;

  assign bus.ack_rf  = w_in_rf && bus.ack_mem;
  assign bus.dat_rf  = bus.ack_rf ? bus.dat_mem2cc : '0;
  assign bus.word_rf = w_in_rf ? w_word : '0;
  assign bus.last_rf = bus.ack_rf && w_last_beat;

  assign bus.ack_wb  = w_in_wb && bus.ack_mem;
  assign bus.word_wb = w_in_wb ? w_word : '0;
  assign bus.last_wb = bus.ack_wb && w_last_beat;

endmodule
`default_nettype wire

// File: tb/tb_cache_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_cache_mem_arbiter
// Purpose  : Scoreboard bench for cache_mem_arbiter with a simple memory model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_cache_mem_arbiter;

  localparam int WW = 32, AW = 32, WN = 4, WOW = 2, SL = 4;

  typedef struct { logic [31:0] adr; logic [31:0] dat; logic [1:0] word; logic last; } beat_t;
  typedef struct { logic wb; logic [31:0] adr; } grant_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  cache_mem_arbiter_if #(.WORD_WIDTH(WW), .ADR_WIDTH(AW), .WORD_OFFSET_WIDTH(WOW)) bus ();

  cache_mem_arbiter #(
    .WORD_WIDTH (WW), .ADR_WIDTH (AW), .WORD_NUM (WN),
    .WORD_OFFSET_WIDTH (WOW), .STARVE_LIMIT (SL)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  beat_t  rf_q[$];
  beat_t  wb_q[$];
  grant_t gnt_q[$];
  int     n_checks = 0;
  int     n_errors = 0;
  int     rf_bursts = 0, wb_bursts = 0, rf_acks = 0, wb_acks = 0;
  int     mem_delay = 0, mem_cnt = 0;
  logic   force_ack = 1'b0;
  logic   prev_req = 1'b0;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s actual=%h expected=%h", tag, act, exp);
    end
  endtask

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0], ~a[15:0]};
  endfunction

  function automatic logic [31:0] wb_word(input logic [1:0] w);
    return {24'hB0B000, 6'd0, w};
  endfunction

  task automatic push_rf(input logic [31:0] a);
    grant_t g;
    beat_t  b;
    logic [1:0] w;
    g.wb = 1'b0; g.adr = {a[31:4], a[3:2], 2'b00};
    gnt_q.push_back(g);
    for (int i = 0; i < WN; i++) begin
      w = a[3:2] + 2'(i);
      b.adr = {a[31:4], w, 2'b00}; b.dat = mem_word(b.adr);
      b.word = w; b.last = (i == WN - 1);
      rf_q.push_back(b);
    end
  endtask

  task automatic push_wb(input logic [31:0] a);
    grant_t g;
    beat_t  b;
    g.wb = 1'b1; g.adr = {a[31:4], 4'h0};
    gnt_q.push_back(g);
    for (int i = 0; i < WN; i++) begin
      b.word = 2'(i); b.adr = {a[31:4], b.word, 2'b00};
      b.dat = wb_word(b.word); b.last = (i == WN - 1);
      wb_q.push_back(b);
    end
  endtask

  task automatic monitor();
    grant_t g;
    beat_t  b;
    if (bus.req_mem && !prev_req) begin
      if (gnt_q.size() == 0) chk("grant_unexpected", 1, 0);
      else begin
        g = gnt_q.pop_front();
        chk("grant_type", bus.rdwr_mem, g.wb);
        chk("grant_adr", bus.adr_mem, g.adr);
      end
    end
    prev_req = bus.req_mem;
    if (bus.ack_mem && !bus.req_mem) begin
      chk("idle_ack_rf", bus.ack_rf, 0);
      chk("idle_ack_wb", bus.ack_wb, 0);
    end else if (bus.ack_mem && !bus.rdwr_mem) begin
      rf_acks++;
      chk("rf_ack", bus.ack_rf, 1);
      if (rf_q.size() == 0) chk("rf_unexpected", 1, 0);
      else begin
        b = rf_q.pop_front();
        chk("rf_adr", bus.adr_mem, b.adr);
        chk("rf_word", bus.word_rf, b.word);
        chk("rf_dat", bus.dat_rf, b.dat);
        chk("rf_last", bus.last_rf, b.last);
        if (b.last && rf_bursts > 0) rf_bursts--;
      end
    end else if (bus.ack_mem) begin
      wb_acks++;
      chk("wb_ack", bus.ack_wb, 1);
      if (wb_q.size() == 0) chk("wb_unexpected", 1, 0);
      else begin
        b = wb_q.pop_front();
        chk("wb_adr", bus.adr_mem, b.adr);
        chk("wb_word", bus.word_wb, b.word);
        chk("wb_dat", bus.dat_cc2mem, b.dat);
        chk("wb_last", bus.last_wb, b.last);
        if (b.last && wb_bursts > 0) wb_bursts--;
      end
    end
    bus.req_rf = (rf_bursts > 0);
    bus.req_wb = (wb_bursts > 0);
  endtask

  // One clock: memory model reacts after the edge, outputs sampled once settled
  task automatic cycle();
    @(posedge clk);
    #1;
    if (force_ack) bus.ack_mem = 1'b1;
    else if (bus.req_mem) begin
      if (mem_cnt >= mem_delay) begin bus.ack_mem = 1'b1; mem_cnt = 0; end
      else begin bus.ack_mem = 1'b0; mem_cnt++; end
    end else begin
      bus.ack_mem = 1'b0; mem_cnt = 0;
    end
    bus.dat_mem2cc = bus.ack_mem ? mem_word(bus.adr_mem) : 32'hDEAD_BEEF;
    bus.dat_wb     = wb_word(bus.word_wb);
    #1;
    monitor();
  endtask

  task automatic wait_done(input string tag, input int budget);
    int n;
    n = 0;
    while ((rf_bursts > 0 || wb_bursts > 0 || bus.req_mem) && n < budget) begin
      cycle();
      n++;
    end
    chk({tag, "_timeout"}, 32'(n >= budget), 0);
    chk({tag, "_rf_left"}, rf_q.size(), 0);
    chk({tag, "_wb_left"}, wb_q.size(), 0);
    chk({tag, "_gnt_left"}, gnt_q.size(), 0);
    cycle();
  endtask

  initial begin
    rst = 1'b1;
    bus.req_rf = 1'b0; bus.adr_rf = '0; bus.req_wb = 1'b0; bus.adr_wb = '0;
    bus.dat_wb = '0; bus.ack_mem = 1'b0; bus.dat_mem2cc = '0;
    repeat (3) cycle();
    chk("rst_req_mem", bus.req_mem, 0);
    chk("rst_rdwr_mem", bus.rdwr_mem, 0);
    chk("rst_adr_mem", bus.adr_mem, 0);
    chk("rst_dat_cc2mem", bus.dat_cc2mem, 0);
    chk("rst_acks", {bus.ack_rf, bus.ack_wb, bus.last_rf, bus.last_wb}, 0);
    chk("rst_dat_rf", bus.dat_rf, 0);
    chk("rst_words", {bus.word_rf, bus.word_wb}, 0);
    rst = 1'b0;
    cycle();

    // Refill only, critical word first, one-cycle arbitration
    bus.adr_rf = 32'h0000_0128; push_rf(bus.adr_rf);
    rf_bursts = 1; bus.req_rf = 1'b1;
    cycle();
    chk("arb_latency", bus.req_mem, 1);
    wait_done("rf_only", 50);

    // Writeback only with slow memory
    mem_delay = 3; wb_acks = 0;
    bus.adr_wb = 32'h0000_0440; push_wb(bus.adr_wb);
    wb_bursts = 1; bus.req_wb = 1'b1;
    wait_done("wb_only", 100);
    chk("wb_ack_count", wb_acks, 4);
    mem_delay = 0;

    // Continuous contention: starvation counter forces writebacks through
    bus.adr_rf = 32'h0000_1008; bus.adr_wb = 32'h0000_3000;
    for (int k = 0; k < 2; k++) begin
      for (int j = 0; j < SL; j++) push_rf(bus.adr_rf);
      push_wb(bus.adr_wb);
    end
    rf_bursts = 2 * SL; wb_bursts = 2; bus.req_rf = 1'b1; bus.req_wb = 1'b1;
    wait_done("starve", 300);

    // Same line on both requesters
    bus.adr_rf = 32'h0000_0200; bus.adr_wb = 32'h0000_0204;
`ifdef ARB_HAZARD_CHECK_EN
    push_wb(bus.adr_wb); push_rf(bus.adr_rf);
`else
    push_rf(bus.adr_rf); push_wb(bus.adr_wb);
`endif
    rf_bursts = 1; wb_bursts = 1; bus.req_rf = 1'b1; bus.req_wb = 1'b1;
    wait_done("hazard", 100);

    // Reset after the second refill beat aborts the burst
    bus.adr_rf = 32'h0000_0128; push_rf(bus.adr_rf);
    rf_bursts = 1; bus.req_rf = 1'b1; rf_acks = 0;
    for (int n = 0; n < 50 && rf_acks < 2; n++) cycle();
    chk("rst_mid_reach", rf_acks, 2);
    rst = 1'b1;
    cycle();
    chk("rst_mid_req_mem", bus.req_mem, 0);
    chk("rst_mid_rdwr", bus.rdwr_mem, 0);
    rst = 1'b0;
    rf_q.delete();
    push_rf(bus.adr_rf);
    wait_done("rst_reissue", 50);

    // Stray memory ack while idle
    force_ack = 1'b1;
    cycle();
    force_ack = 1'b0;
    cycle();
    chk("stray_req_mem", bus.req_mem, 0);
    bus.adr_rf = 32'h0000_5554; push_rf(bus.adr_rf);
    rf_bursts = 1; bus.req_rf = 1'b1;
    wait_done("post_stray", 50);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
